// File: rtl/key_debounce_sync.sv
// Two-flop synchroniser plus per-key hold-counter debouncer for board push-buttons.
// Emits a clean pressed level and one-cycle press/release pulses per key.
module key_debounce_sync #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any
);

    generate
        if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_params
            $error("key_debounce_sync: CNT_W too small or DEBOUNCE_CYCLES < 1");
        end
    endgenerate

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] RELEASED_PINS = {NUM_KEYS{ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync_s1_reg;
    logic [NUM_KEYS-1:0] sync_s2_reg;
    logic [NUM_KEYS-1:0] key_pressed;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1_reg <= RELEASED_PINS;
            sync_s2_reg <= RELEASED_PINS;
        end else begin
            sync_s1_reg <= key_raw;
            sync_s2_reg <= sync_s1_reg;
        end
    end

    assign key_pressed = ACTIVE_LOW ? ~sync_s2_reg : sync_s2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_state_t       state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             press_reg;
            logic             release_reg;

            // The counter only runs while the synced input disagrees with the
            // accepted state; any agreeing cycle throws the partial count away.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg   <= KEY_RELEASED;
                    cnt_reg     <= '0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    case (state_reg)
                        KEY_RELEASED: begin
                            if (key_pressed[gi]) begin
                                if (cnt_reg == CNT_LAST) begin
                                    state_reg <= KEY_PRESSED;
                                    cnt_reg   <= '0;
                                    press_reg <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        KEY_PRESSED: begin
                            if (!key_pressed[gi]) begin
                                if (cnt_reg == CNT_LAST) begin
                                    state_reg   <= KEY_RELEASED;
                                    cnt_reg     <= '0;
                                    release_reg <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end else begin
                                cnt_reg <= '0;
                            end
                        end
                        default: begin
                            state_reg <= KEY_RELEASED;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign key_level[gi]   = (state_reg == KEY_PRESSED);
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;
        end
    endgenerate

    assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce_sync.sv
// Self-checking bench for key_debounce_sync: directed scenarios plus random bouncing,
// checked against a timestamp-based model of "input stable long enough".
module tb_key_debounce_sync;

    localparam int NK  = 4;
    localparam int DC  = 4;
    localparam int CW  = 3;
    localparam bit AL  = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          key_any;

    int tests  = 0;
    int errors = 0;

    key_debounce_sync #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(CW), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw), .key_level(key_level),
        .key_press(key_press), .key_release(key_release), .key_any(key_any)
    );

    always #5 clk = ~clk;

    // Reference model: the raw pins reach the debouncer two edges late; a key's level
    // flips once its delayed pressed value has differed from the level and stayed
    // unchanged for DC consecutive edges (tracked by the edge of its last change).
    int            cyc = 0;
    logic [NK-1:0] m_d1, m_d2, m_prev_p, m_level, m_press, m_rel, p_now;
    int            m_since [NK];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_d1 = {NK{AL}};
            m_d2 = {NK{AL}};
            m_prev_p = '0;
            m_level  = '0;
            m_press  = '0;
            m_rel    = '0;
        end else begin
            p_now   = AL ? ~m_d2 : m_d2;
            m_press = '0;
            m_rel   = '0;
            for (int i = 0; i < NK; i++) begin
                if (p_now[i] != m_prev_p[i]) m_since[i] = cyc;
                if (p_now[i] != m_level[i] && (cyc - m_since[i]) >= DC - 1) begin
                    m_level[i] = p_now[i];
                    if (p_now[i]) m_press[i] = 1'b1;
                    else          m_rel[i]   = 1'b1;
                end
            end
            m_prev_p = p_now;
            m_d2 = m_d1;
            m_d1 = key_raw;
        end
    end

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_raw = 4'hF;
        settle(3);
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            tests++;
            if ({key_level, key_press, key_release, key_any} !== 13'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got lvl=%h prs=%h rel=%h any=%b, want all 0",
                         j, key_level, key_press, key_release, key_any);
            end
        end
    endtask

    task automatic test_press();
        key_raw = 4'hE;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== ((j >= 5) ? 4'h1 : 4'h0) || key_press !== ((j == 5) ? 4'h1 : 4'h0) ||
                key_release !== 4'h0 || key_any !== (j >= 5) ||
                key_level !== m_level || key_press !== m_press) begin
                errors++;
                $display("FAIL press j=%0d: got lvl=%h prs=%h rel=%h any=%b, want lvl=%h prs=%h",
                         j, key_level, key_press, key_release, key_any,
                         (j >= 5) ? 4'h1 : 4'h0, (j == 5) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_bounce();
        key_raw = 4'hC;
        settle(3);
        key_raw = 4'hE;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== 4'h1 || key_press !== 4'h0 || key_release !== 4'h0 ||
                key_level !== m_level) begin
                errors++;
                $display("FAIL bounce j=%0d: got lvl=%h prs=%h rel=%h, want lvl=1 prs=0 rel=0",
                         j, key_level, key_press, key_release);
            end
        end
    endtask

    task automatic test_release();
        key_raw = 4'hF;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== ((j >= 5) ? 4'h0 : 4'h1) || key_release !== ((j == 5) ? 4'h1 : 4'h0) ||
                key_press !== 4'h0 || key_release !== m_rel) begin
                errors++;
                $display("FAIL release j=%0d: got lvl=%h rel=%h prs=%h, want lvl=%h rel=%h",
                         j, key_level, key_release, key_press,
                         (j >= 5) ? 4'h0 : 4'h1, (j == 5) ? 4'h1 : 4'h0);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_raw = 4'h5;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== ((j >= 5) ? 4'hA : 4'h0) || key_press !== ((j == 5) ? 4'hA : 4'h0) ||
                key_release !== 4'h0 || key_any !== (j >= 5)) begin
                errors++;
                $display("FAIL simultaneous j=%0d: got lvl=%h prs=%h any=%b, want lvl=%h prs=%h",
                         j, key_level, key_press, key_any,
                         (j >= 5) ? 4'hA : 4'h0, (j == 5) ? 4'hA : 4'h0);
            end
        end
        key_raw = 4'hF;
        settle(10);
    endtask

    task automatic test_reset_mid();
        key_raw = 4'hB;
        settle(4);             // count for key 2 has reached 2
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (key_level !== 4'h0 || key_press !== 4'h0 || key_release !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid in-reset: got lvl=%h prs=%h rel=%h, want 0",
                     key_level, key_press, key_release);
        end
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== ((j >= 6) ? 4'h4 : 4'h0) || key_press !== ((j == 6) ? 4'h4 : 4'h0) ||
                key_release !== 4'h0) begin
                errors++;
                $display("FAIL reset_mid j=%0d: got lvl=%h prs=%h rel=%h, want lvl=%h prs=%h",
                         j, key_level, key_press, key_release,
                         (j >= 6) ? 4'h4 : 4'h0, (j == 6) ? 4'h4 : 4'h0);
            end
        end
        key_raw = 4'hF;
        settle(10);
    endtask

    task automatic test_random();
        int hold = 0;
        for (int j = 0; j < 2000; j++) begin
            @(negedge clk);
            tests++;
            if (key_level !== m_level || key_press !== m_press || key_release !== m_rel ||
                key_any !== (|m_level) || (key_press & key_release) !== 4'h0) begin
                errors++;
                $display("FAIL random j=%0d: got lvl=%h prs=%h rel=%h any=%b, want lvl=%h prs=%h rel=%h",
                         j, key_level, key_press, key_release, key_any, m_level, m_press, m_rel);
            end
            reset = ($urandom_range(0, 299) == 0);
            if (hold == 0) begin
                key_raw = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NK; i++) m_since[i] = 0;
        reset = 1'b1;
        key_raw = 4'hF;
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
